onehot_decoder_pipe: RTL

- Inverse of the codebase's priority encoder: takes an index plus a nonzero flag and produces a registered one-hot vector with valid/ready flow control.
- Sits downstream of the priority encoder, for example in arbitration and grant paths.
- Round-trip rule: feeding the encoder's (out, valid) into this block yields the encoder input's highest set bit as a one-hot vector.
- Buffering is a 2-entry skid (main plus skid register), so `in_ready` never depends combinationally on `out_ready`.

---
 rtl/onehot_codec_pkg.sv | 23 ++
 rtl/onehot_skid_buf.sv | 69 ++++++
 rtl/onehot_decoder_pipe.sv | 77 +++++++
 3 files changed

// File: rtl/onehot_codec_pkg.sv
// Shared types and width helpers for the one-hot decode path.
package onehot_codec_pkg;

    localparam int ERRCNT_W = 8;
    localparam int DEC_W    = 8;

    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    typedef struct packed {
        logic [DEC_W-1:0] onehot;
        logic             err;
    } dec_beat_t;

    // Bit 0 = main register valid, bit 1 = skid register valid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry valid/ready register pair (main + skid); accept readiness is a pure state bit.
module onehot_skid_buf
    import onehot_codec_pkg::*;
#(
    parameter type T = dec_beat_t
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  T            in_data,
    input  logic        out_ready,
    output T            out_data,
    output skid_state_e state
);

    skid_state_e r_state;
    T            r_main;
    T            r_skid;
    logic        w_accept;
    logic        w_drain;

    assign w_accept = in_valid && (r_state != SKID_FULL);
    assign w_drain  = (r_state != SKID_EMPTY) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_drain) begin
                        r_skid  <= in_data;
                        r_state <= SKID_FULL;
                    end else if (w_accept && w_drain) begin
                        r_main  <= in_data;
                    end else if (w_drain) begin
                        r_main  <= '0;
                        r_state <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // Skid content is older than anything upstream, so it refills main first.
                    if (w_drain) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= SKID_ONE;
                    end
                end
                default: begin
                    r_state <= SKID_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

    assign out_data = r_main;
    assign state    = r_state;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered index-to-one-hot decoder with skid buffering; ONEHOT_DEC_ERRCNT_EN adds err_count.
module onehot_decoder_pipe
    import onehot_codec_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_nz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_err
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] onehot;
        logic             err;
    } beat_t;

    // Indices past WIDTH only exist for non-power-of-two widths; they decode to an error beat.
    function automatic beat_t decode(input logic [IDX_W-1:0] idx, input logic nz);
        beat_t b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b.onehot[i] = nz && (int'(idx) == i);
        end
        b.err = nz && (int'(idx) >= WIDTH);
        return b;
    endfunction

    beat_t       w_beat_in;
    beat_t       w_beat_out;
    skid_state_e w_state;

    assign w_beat_in = decode(in_idx, in_nz);

    onehot_skid_buf #(
        .T(beat_t)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (w_beat_in),
        .out_ready(out_ready),
        .out_data (w_beat_out),
        .state    (w_state)
    );

    assign in_ready   = (w_state != SKID_FULL);
    assign out_valid  = (w_state != SKID_EMPTY);
    assign out_onehot = w_beat_out.onehot;
    assign out_err    = w_beat_out.err;

`ifdef ONEHOT_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (out_valid && out_ready && out_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
